pipe_seq_ctl: RTL and testbench

// - Pipeline sequencer for the PC generator and the register-file read port: issues the pc_prectl override

---
 rtl/pipe_seq_ctl_pkg.sv | 22 ++
 rtl/pipe_seq_ctl_if.sv | 39 +++
 rtl/hazard_det.sv | 17 +
 rtl/pipe_seq_ctl.sv | 123 ++++++++++++
 tb/tb_pipe_seq_ctl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_seq_ctl_pkg.sv
// Shared codes for the pipeline sequencer: pc_gen control codes, sequencer states
// and register-address width.
package pipe_seq_ctl_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    PC_IGN = 4'd0,
    PC_KEP = 4'd1,
    PC_IRQ = 4'd2,
    PC_RST = 4'd3,
    PC_RET = 4'd4
  } pc_ctl_e;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_IRQ   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/pipe_seq_ctl_if.sv
// Signal bundle between the ID-stage decoder, the sequencer and pc_gen/reg_array.
// master = sequencer side, slave = decoder/pc_gen side.
interface pipe_seq_ctl_if
  import pipe_seq_ctl_pkg::*;
#(
  parameter int AW = 32
) ();

  logic              ex_load;
  logic [REG_AW-1:0] ex_rd;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rt;
  logic              id_dslot;
  logic              id_ret;
  logic [AW-1:0]     id_pc;
  logic              irq_req;
  logic              irq_en;
  pc_ctl_e           pc_prectl;
  logic              rd_clk_cls;
  logic              ex_bubble;
  logic              id_flush;
  logic              irq_ack;
  logic              in_isr;
  logic [AW-1:0]     zz_spc;

  modport master (
    input  ex_load, ex_rd, id_rs, id_rt, id_use_rt, id_dslot, id_ret, id_pc,
           irq_req, irq_en,
    output pc_prectl, rd_clk_cls, ex_bubble, id_flush, irq_ack, in_isr, zz_spc
  );

  modport slave (
    output ex_load, ex_rd, id_rs, id_rt, id_use_rt, id_dslot, id_ret, id_pc,
           irq_req, irq_en,
    input  pc_prectl, rd_clk_cls, ex_bubble, id_flush, irq_ack, in_isr, zz_spc
  );

endinterface

// File: rtl/hazard_det.sv
// Load-use hazard compare between the EX destination and the ID source registers.
module hazard_det
  import pipe_seq_ctl_pkg::*;
(
  input  logic              ex_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rt,
  output logic              hazard
);

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign hazard = ex_load && (ex_rd != '0) &&
                  ((ex_rd == id_rs) || (id_use_rt && (ex_rd == id_rt)));

endmodule

// File: rtl/pipe_seq_ctl.sv
// Pipeline sequencer: reset hold-off, load-use stall, interrupt entry/return, saved PC.
// Optional PIPE_PERF_EN adds stall_cnt / irq_cnt performance counters.
module pipe_seq_ctl
  import pipe_seq_ctl_pkg::*;
#(
  parameter int RST_CYC = 4,
  parameter int AW      = 32
) (
  input  logic                  clock,
  input  logic                  rst_n,
  pipe_seq_ctl_if.master        bus
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [15:0]           irq_cnt
`endif
);

  seq_state_e    state, state_nxt;
  logic [3:0]    count;
  logic [AW-1:0] spc_q;
  logic          isr_q;
  logic          hazard;
  logic          take;
  logic          ret_clr;
  pc_ctl_e       pc_ctl;
  logic          rd_cls, bubble, flush, ack;

  hazard_det u_hazard_det (
    .ex_load   (bus.ex_load),
    .ex_rd     (bus.ex_rd),
    .id_rs     (bus.id_rs),
    .id_rt     (bus.id_rt),
    .id_use_rt (bus.id_use_rt),
    .hazard    (hazard)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RST;
      count <= 4'd0;
      spc_q <= '0;
      isr_q <= 1'b0;
    end else begin
      state <= state_nxt;
      // hold-off counter saturates instead of wrapping
      if (state == ST_RST && count != 4'hF)
        count <= count + 4'd1;
      if (take) begin
        spc_q <= bus.id_pc;
        isr_q <= 1'b1;
      end else if (ret_clr) begin
        isr_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pc_ctl    = PC_IGN;
    rd_cls    = 1'b0;
    bubble    = 1'b0;
    flush     = 1'b0;
    ack       = 1'b0;
    take      = 1'b0;
    ret_clr   = 1'b0;
    case (state)
      ST_RST: begin
        pc_ctl = PC_RST;
        rd_cls = 1'b1;
        bubble = 1'b1;
        flush  = 1'b1;
        if (count >= 4'(RST_CYC - 1))
          state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // hazard wins over irq, so a stalled instruction is never the interrupted one
        if (hazard) begin
          pc_ctl    = PC_KEP;
          rd_cls    = 1'b1;
          bubble    = 1'b1;
          state_nxt = ST_STALL;
        end else begin
          take = bus.irq_req && bus.irq_en && !isr_q && !bus.id_dslot && !bus.id_ret;
          ret_clr = bus.id_ret;
          if (take) begin
            pc_ctl    = PC_IRQ;
            flush     = 1'b1;
            bubble    = 1'b1;
            ack       = 1'b1;
            state_nxt = ST_IRQ;
          end
        end
      end
      ST_STALL: state_nxt = ST_RUN;
      ST_IRQ:   state_nxt = ST_RUN;
      default:  state_nxt = ST_RST;
    endcase
  end

  assign bus.pc_prectl  = pc_ctl;
  assign bus.rd_clk_cls = rd_cls;
  assign bus.ex_bubble  = bubble;
  assign bus.id_flush   = flush;
  assign bus.irq_ack    = ack;
  assign bus.in_isr     = isr_q;
  assign bus.zz_spc     = spc_q;

`ifdef PIPE_PERF_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
      irq_cnt   <= 16'd0;
    end else begin
      if (state == ST_STALL)
        stall_cnt <= stall_cnt + 32'd1;
      if (ack)
        irq_cnt <= irq_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_seq_ctl.sv
// Directed self-checking bench for pipe_seq_ctl (RST_CYC=4, AW=32).
module tb_pipe_seq_ctl;
  import pipe_seq_ctl_pkg::*;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  pipe_seq_ctl_if #(.AW(32)) bus ();

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt;
  logic [15:0] irq_cnt;
`endif

  pipe_seq_ctl #(.RST_CYC(4), .AW(32)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PIPE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .irq_cnt   (irq_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic idle_inputs();
    bus.ex_load = 1'b0; bus.ex_rd = 5'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
    bus.id_use_rt = 1'b0; bus.id_dslot = 1'b0; bus.id_ret = 1'b0; bus.id_pc = 32'd0;
    bus.irq_req = 1'b0; bus.irq_en = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clock); rst_n = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    tests++; if (bus.pc_prectl !== PC_RST) begin fails++; $display("FAIL rst_pc: got %0d want %0d", bus.pc_prectl, PC_RST); end
    tests++; if ({bus.rd_clk_cls, bus.ex_bubble, bus.id_flush} !== 3'b111) begin fails++; $display("FAIL rst_ctl: got %b want 111", {bus.rd_clk_cls, bus.ex_bubble, bus.id_flush}); end
    tests++; if ({bus.irq_ack, bus.in_isr} !== 2'b00) begin fails++; $display("FAIL rst_irq: got %b want 00", {bus.irq_ack, bus.in_isr}); end
    tests++; if (bus.zz_spc !== 32'd0) begin fails++; $display("FAIL rst_spc: got %0h want 0", bus.zz_spc); end
    @(negedge clock); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if (bus.pc_prectl !== PC_RST || bus.rd_clk_cls !== 1'b1) begin fails++; $display("FAIL rst_hold%0d: pc=%0d cls=%b want %0d 1", i, bus.pc_prectl, bus.rd_clk_cls, PC_RST); end
      @(negedge clock);
    end
    #1;
    tests++; if (bus.pc_prectl !== PC_IGN || bus.rd_clk_cls !== 1'b0) begin fails++; $display("FAIL rst_run: pc=%0d cls=%b want %0d 0", bus.pc_prectl, bus.rd_clk_cls, PC_IGN); end
  endtask

  task automatic test_load_use();
    @(negedge clock);
    bus.ex_load = 1'b1; bus.ex_rd = 5'd5; bus.id_rs = 5'd5; #1;
    tests++; if (bus.pc_prectl !== PC_KEP) begin fails++; $display("FAIL lu_pc: got %0d want %0d", bus.pc_prectl, PC_KEP); end
    tests++; if ({bus.rd_clk_cls, bus.ex_bubble, bus.id_flush} !== 3'b110) begin fails++; $display("FAIL lu_ctl: got %b want 110", {bus.rd_clk_cls, bus.ex_bubble, bus.id_flush}); end
    @(negedge clock); #1;
    tests++; if (bus.pc_prectl !== PC_IGN || {bus.rd_clk_cls, bus.ex_bubble} !== 2'b00) begin fails++; $display("FAIL lu_after: pc=%0d ctl=%b want %0d 00", bus.pc_prectl, {bus.rd_clk_cls, bus.ex_bubble}, PC_IGN); end
    idle_inputs();
    @(negedge clock);
    bus.ex_load = 1'b1; bus.ex_rd = 5'd0; bus.id_rs = 5'd0; #1;
    tests++; if (bus.pc_prectl !== PC_IGN) begin fails++; $display("FAIL lu_r0: got %0d want %0d", bus.pc_prectl, PC_IGN); end
    bus.ex_rd = 5'd5; bus.id_rs = 5'd3; bus.id_rt = 5'd5; bus.id_use_rt = 1'b0; #1;
    tests++; if (bus.pc_prectl !== PC_IGN) begin fails++; $display("FAIL lu_rt_unused: got %0d want %0d", bus.pc_prectl, PC_IGN); end
    bus.id_use_rt = 1'b1; #1;
    tests++; if (bus.pc_prectl !== PC_KEP) begin fails++; $display("FAIL lu_rt_used: got %0d want %0d", bus.pc_prectl, PC_KEP); end
    @(negedge clock); idle_inputs();
    @(negedge clock);
  endtask

  task automatic test_irq_entry();
    bus.irq_en = 1'b1; bus.irq_req = 1'b1; bus.id_pc = 32'h0000_0120; #1;
    tests++; if (bus.pc_prectl !== PC_IRQ) begin fails++; $display("FAIL irq_pc: got %0d want %0d", bus.pc_prectl, PC_IRQ); end
    tests++; if ({bus.id_flush, bus.ex_bubble, bus.irq_ack} !== 3'b111) begin fails++; $display("FAIL irq_ctl: got %b want 111", {bus.id_flush, bus.ex_bubble, bus.irq_ack}); end
    @(negedge clock); #1;
    tests++; if (bus.zz_spc !== 32'h120 || bus.in_isr !== 1'b1) begin fails++; $display("FAIL irq_saved: spc=%0h isr=%b want 120 1", bus.zz_spc, bus.in_isr); end
    tests++; if (bus.irq_ack !== 1'b0 || bus.pc_prectl !== PC_IGN) begin fails++; $display("FAIL irq_vec: ack=%b pc=%0d want 0 %0d", bus.irq_ack, bus.pc_prectl, PC_IGN); end
    @(negedge clock); bus.id_pc = 32'h200; #1;
    tests++; if (bus.irq_ack !== 1'b0 || bus.pc_prectl !== PC_IGN) begin fails++; $display("FAIL irq_masked: ack=%b pc=%0d want 0 %0d", bus.irq_ack, bus.pc_prectl, PC_IGN); end
    @(negedge clock); #1;
    tests++; if (bus.zz_spc !== 32'h120) begin fails++; $display("FAIL irq_spc_hold: got %0h want 120", bus.zz_spc); end
  endtask

  task automatic test_return();
    bus.irq_req = 1'b0; bus.id_ret = 1'b1; #1;
    tests++; if (bus.pc_prectl !== PC_IGN || bus.irq_ack !== 1'b0) begin fails++; $display("FAIL ret_pc: pc=%0d ack=%b want %0d 0", bus.pc_prectl, bus.irq_ack, PC_IGN); end
    @(negedge clock); bus.id_ret = 1'b0; #1;
    tests++; if (bus.in_isr !== 1'b0 || bus.zz_spc !== 32'h120) begin fails++; $display("FAIL ret_state: isr=%b spc=%0h want 0 120", bus.in_isr, bus.zz_spc); end
  endtask

  task automatic test_dslot();
    @(negedge clock);
    bus.irq_en = 1'b1; bus.irq_req = 1'b1; bus.id_dslot = 1'b1; bus.id_pc = 32'h300; #1;
    tests++; if (bus.irq_ack !== 1'b0 || bus.pc_prectl !== PC_IGN) begin fails++; $display("FAIL ds_defer: ack=%b pc=%0d want 0 %0d", bus.irq_ack, bus.pc_prectl, PC_IGN); end
    @(negedge clock); #1;
    tests++; if (bus.in_isr !== 1'b0 || bus.irq_ack !== 1'b0) begin fails++; $display("FAIL ds_defer2: isr=%b ack=%b want 0 0", bus.in_isr, bus.irq_ack); end
    bus.id_dslot = 1'b0; bus.id_pc = 32'h304; #1;
    tests++; if (bus.irq_ack !== 1'b1 || bus.pc_prectl !== PC_IRQ) begin fails++; $display("FAIL ds_take: ack=%b pc=%0d want 1 %0d", bus.irq_ack, bus.pc_prectl, PC_IRQ); end
    @(negedge clock); bus.irq_req = 1'b0; #1;
    tests++; if (bus.zz_spc !== 32'h304 || bus.in_isr !== 1'b1) begin fails++; $display("FAIL ds_spc: spc=%0h isr=%b want 304 1", bus.zz_spc, bus.in_isr); end
    @(negedge clock); bus.id_ret = 1'b1;
    @(negedge clock); bus.id_ret = 1'b0; #1;
    tests++; if (bus.in_isr !== 1'b0) begin fails++; $display("FAIL ds_ret: isr=%b want 0", bus.in_isr); end
  endtask

  task automatic test_collision();
    @(negedge clock);
    bus.irq_en = 1'b1; bus.irq_req = 1'b1; bus.id_pc = 32'h400;
    bus.ex_load = 1'b1; bus.ex_rd = 5'd7; bus.id_rs = 5'd7; #1;
    tests++; if (bus.pc_prectl !== PC_KEP || bus.irq_ack !== 1'b0) begin fails++; $display("FAIL col_stall: pc=%0d ack=%b want %0d 0", bus.pc_prectl, bus.irq_ack, PC_KEP); end
    @(negedge clock); bus.ex_load = 1'b0; #1;
    tests++; if (bus.irq_ack !== 1'b0 || bus.pc_prectl !== PC_IGN) begin fails++; $display("FAIL col_stallcyc: ack=%b pc=%0d want 0 %0d", bus.irq_ack, bus.pc_prectl, PC_IGN); end
    @(negedge clock); #1;
    tests++; if (bus.irq_ack !== 1'b1 || bus.pc_prectl !== PC_IRQ) begin fails++; $display("FAIL col_take: ack=%b pc=%0d want 1 %0d", bus.irq_ack, bus.pc_prectl, PC_IRQ); end
    @(negedge clock); bus.irq_req = 1'b0; #1;
    tests++; if (bus.zz_spc !== 32'h400 || bus.in_isr !== 1'b1) begin fails++; $display("FAIL col_spc: spc=%0h isr=%b want 400 1", bus.zz_spc, bus.in_isr); end
  endtask

  task automatic test_midop_reset();
    @(negedge clock);
    bus.ex_load = 1'b1; bus.ex_rd = 5'd9; bus.id_rs = 5'd9;
    @(negedge clock); bus.ex_load = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    tests++; if (bus.pc_prectl !== PC_RST || bus.rd_clk_cls !== 1'b1) begin fails++; $display("FAIL mid_pc: pc=%0d cls=%b want %0d 1", bus.pc_prectl, bus.rd_clk_cls, PC_RST); end
    tests++; if (bus.zz_spc !== 32'd0 || bus.in_isr !== 1'b0) begin fails++; $display("FAIL mid_spc: spc=%0h isr=%b want 0 0", bus.zz_spc, bus.in_isr); end
    idle_inputs();
    repeat (3) @(negedge clock);
    release_reset();
    #1;
    tests++; if (bus.pc_prectl !== PC_IGN) begin fails++; $display("FAIL mid_run: got %0d want %0d", bus.pc_prectl, PC_IGN); end
  endtask

  task automatic test_perf();
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      bus.ex_load = 1'b1; bus.ex_rd = 5'd4; bus.id_rt = 5'd4; bus.id_use_rt = 1'b1; #1;
      tests++; if (bus.pc_prectl !== PC_KEP) begin fails++; $display("FAIL perf_haz%0d: got %0d want %0d", k, bus.pc_prectl, PC_KEP); end
      @(negedge clock); idle_inputs();
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      bus.irq_en = 1'b1; bus.irq_req = 1'b1; bus.id_pc = 32'h500 + 32'(k * 4); #1;
      tests++; if (bus.irq_ack !== 1'b1) begin fails++; $display("FAIL perf_irq%0d: ack=%b want 1", k, bus.irq_ack); end
      @(negedge clock); bus.irq_req = 1'b0;
      @(negedge clock); bus.id_ret = 1'b1;
      @(negedge clock); bus.id_ret = 1'b0;
    end
    @(negedge clock); #1;
    tests++; if (bus.zz_spc !== 32'h504) begin fails++; $display("FAIL perf_spc: got %0h want 504", bus.zz_spc); end
`ifdef PIPE_PERF_EN
    tests++; if (stall_cnt !== 32'd3) begin fails++; $display("FAIL perf_stall_cnt: got %0d want 3", stall_cnt); end
    tests++; if (irq_cnt !== 16'd2) begin fails++; $display("FAIL perf_irq_cnt: got %0d want 2", irq_cnt); end
`endif
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_irq_entry();
    test_return();
    test_dslot();
    test_collision();
    test_midop_reset();
    test_perf();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
